// File: rtl/detonator_code_ctrl.sv
// Passcode store, change-passcode sequencer and failed-attempt lockout for the detonator.
// Build option: `define CODE_TIMEOUT_EN adds an inactivity timeout to the change sequence.
module detonator_code_ctrl #(
   parameter logic [15:0] INIT_CODE   = 16'h2580,
   parameter int          MAX_FAIL    = 3,
   parameter logic [15:0] LOCK_CYCLES = 16'd100
`ifdef CODE_TIMEOUT_EN
  ,parameter logic [15:0] TIMEOUT_CYCLES = 16'd200
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_vld,
   input  logic [3:0]  key_code,
   input  logic        sure,
   input  logic        chg_req,
   input  logic        chg_abort,
   input  logic        chk_vld,
   input  logic [15:0] chk_code,
   output logic        chk_done,
   output logic        chk_pass,
   output logic        chg_ok,
   output logic        chg_err,
   output logic        lock,
   output logic        busy,
   output logic [1:0]  fail_cnt,
   output logic [15:0] code_out
);

   // Handshake: key_vld, sure and chk_vld are single-cycle strobes with no back-pressure;
   // every chk_vld is answered by exactly one chk_done pulse on the following cycle.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_OLD    = 3'd1,
      S_NEW    = 3'd2,
      S_CONF   = 3'd3,
      S_LOCKED = 3'd4
   } state_t;

   localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);

   state_t      state, state_d;
   logic [15:0] ebuf, ebuf_d;
   logic [15:0] nbuf, nbuf_d;
   logic [2:0]  dcnt, dcnt_d;
   logic [15:0] lock_cnt, lock_cnt_d;
   logic [15:0] code_d;
   logic [1:0]  fail_d;
   logic [1:0]  fail_inc;
   logic        chk_done_d, chk_pass_d, chg_ok_d, chg_err_d, lock_d, busy_d;
   logic        digit_ok;
`ifdef CODE_TIMEOUT_EN
   logic [15:0] timer, timer_d;
`endif

   assign digit_ok = key_vld && (key_code <= 4'd9);
   assign fail_inc = fail_cnt + 2'd1;

   always_comb begin
      state_d    = state;
      ebuf_d     = ebuf;
      nbuf_d     = nbuf;
      dcnt_d     = dcnt;
      lock_cnt_d = lock_cnt;
      code_d     = code_out;
      fail_d     = fail_cnt;
      chk_done_d = 1'b0;
      chk_pass_d = 1'b0;
      chg_ok_d   = 1'b0;
      chg_err_d  = 1'b0;
`ifdef CODE_TIMEOUT_EN
      timer_d    = (key_vld || sure) ? 16'd0 : timer + 16'd1;
`endif

      case (state)
         S_IDLE: begin
            // A check wins over a simultaneous change request.
            if (chk_vld) begin
               chk_done_d = 1'b1;
               if (chk_code == code_out) begin
                  chk_pass_d = 1'b1;
                  fail_d     = 2'd0;
               end else begin
                  fail_d = fail_inc;
                  if (fail_inc == FAIL_LIMIT) state_d = S_LOCKED;
               end
            end else if (chg_req) begin
               state_d = S_OLD;
            end
         end

         S_OLD, S_NEW, S_CONF: begin
            if (chk_vld) chk_done_d = 1'b1;
            if (chg_abort) begin
               chg_err_d = 1'b1;
               state_d   = S_IDLE;
            end else if (sure) begin
               if (dcnt != 3'd4) begin
                  chg_err_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  case (state)
                     S_OLD: begin
                        if (ebuf == code_out) begin
                           state_d = S_NEW;
                           fail_d  = 2'd0;
                        end else begin
                           // A wrong old code is an attempt failure just like a failed check.
                           chg_err_d = 1'b1;
                           fail_d    = fail_inc;
                           state_d   = (fail_inc == FAIL_LIMIT) ? S_LOCKED : S_IDLE;
                        end
                     end
                     S_NEW: begin
                        nbuf_d  = ebuf;
                        state_d = S_CONF;
                     end
                     default: begin
                        if (ebuf == nbuf) begin
                           code_d   = nbuf;
                           chg_ok_d = 1'b1;
                        end else begin
                           chg_err_d = 1'b1;
                        end
                        state_d = S_IDLE;
                     end
                  endcase
               end
            end else if (digit_ok) begin
               if (dcnt == 3'd4) begin
                  chg_err_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  ebuf_d = {ebuf[11:0], key_code};
                  dcnt_d = dcnt + 3'd1;
               end
            end
`ifdef CODE_TIMEOUT_EN
            else if (!key_vld && (timer == TIMEOUT_CYCLES - 16'd1)) begin
               chg_err_d = 1'b1;
               state_d   = S_IDLE;
            end
`endif
         end

         S_LOCKED: begin
            if (chk_vld) chk_done_d = 1'b1;
            if (lock_cnt == 16'd0) begin
               state_d = S_IDLE;
               fail_d  = 2'd0;
            end else begin
               lock_cnt_d = lock_cnt - 16'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Entry into any state starts with an empty entry buffer and fresh counters.
      if (state_d != state) begin
         dcnt_d = 3'd0;
         ebuf_d = 16'd0;
`ifdef CODE_TIMEOUT_EN
         timer_d = 16'd0;
`endif
         if (state_d == S_LOCKED) lock_cnt_d = LOCK_CYCLES - 16'd1;
      end

      busy_d = (state_d == S_OLD) || (state_d == S_NEW) || (state_d == S_CONF);
      lock_d = (state_d == S_LOCKED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         ebuf     <= 16'd0;
         nbuf     <= 16'd0;
         dcnt     <= 3'd0;
         lock_cnt <= 16'd0;
         code_out <= INIT_CODE;
         fail_cnt <= 2'd0;
         chk_done <= 1'b0;
         chk_pass <= 1'b0;
         chg_ok   <= 1'b0;
         chg_err  <= 1'b0;
         lock     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         ebuf     <= ebuf_d;
         nbuf     <= nbuf_d;
         dcnt     <= dcnt_d;
         lock_cnt <= lock_cnt_d;
         code_out <= code_d;
         fail_cnt <= fail_d;
         chk_done <= chk_done_d;
         chk_pass <= chk_pass_d;
         chg_ok   <= chg_ok_d;
         chg_err  <= chg_err_d;
         lock     <= lock_d;
         busy     <= busy_d;
      end
   end

`ifdef CODE_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) timer <= 16'd0;
      else      timer <= timer_d;
   end
`endif

endmodule
